int_sequencer: RTL and testbench
================================

# int_sequencer

Interrupt and return sequencer for the five-stage 16-bit pipeline. It latches the external interrupt request and drains the pipeline, then saves the resume PC on the stack through the memory stage and redirects fetch to the interrupt vector. On RTI it reverses the sequence, restoring the saved PC. It drives the `count` input of the hazard detection unit and the fetch stall/flush lines while a sequence is in progress.

## Interface
- `PC_W`, 32, program counter width; must be 32 (two 16-bit stack words).
- `DRAIN_CYCLES`, 3, cycles held in DRAIN so instructions in DE/EM/MW retire.
- `VECTOR_ADDR`, 32'h0000_0002, fetch target on interrupt entry.
- `clk` in 1: pipeline clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `int_req` in 1: external interrupt; rising edge sets a pending latch.
- `rti` in 1: one-cycle pulse from decode when an RTI instruction is decoded.
- `pc_next` in PC_W: PC of the next instruction to fetch (includes any taken branch).
- `pop_data` in 16: stack read data; valid the cycle after `pop_req`.
- `stall_fetch` out 1: freeze PC and FD buffer.
- `flush_fd` out 1: flush FD buffer.
- `flush_de` out 1: flush DE buffer.
- `push_req` out 1: memory stage stack push this cycle.
- `push_data` out 16: word to push.
- `pop_req` out 1: memory stage stack pop this cycle.
- `pc_load` out 1: load `pc_load_addr` into PC this cycle.
- `pc_load_addr` out PC_W: redirect target.
- `int_count` out 2: sequence phase for the HDU (0 idle, 1 drain, 2 stack op, 3 redirect).
- `in_isr` out 1: set between interrupt redirect and RTI completion.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, DRAIN, PUSH_HI, PUSH_LO, VECTOR, POP_LO, POP_HI, RESUME.
- IDLE → DRAIN when `pending && !in_isr`. Load the drain counter with `DRAIN_CYCLES-1`.
- DRAIN:
  - `stall_fetch=1`, `flush_fd=1`, `int_count=1`.
  - Decrement the counter. At 0, capture `pc_next` into `save_pc` and go to PUSH_HI.
- PUSH_HI: `push_req=1`, `push_data=save_pc[31:16]`, `int_count=2`. Go to PUSH_LO.
- PUSH_LO: `push_req=1`, `push_data=save_pc[15:0]`. Go to VECTOR.
- VECTOR:
  - `pc_load=1`, `pc_load_addr=VECTOR_ADDR`, `int_count=3`.
  - Clear `pending`, set `in_isr`, go to IDLE.
- IDLE → POP_LO on `rti` when `in_isr`. `flush_fd` and `flush_de` are high in the `rti` cycle.
- POP_LO: `pop_req=1`, `stall_fetch=1`, `int_count=2`. Go to POP_HI.
- POP_HI:
  - `pop_req=1`. Capture `pop_data` into `save_pc[15:0]`. Go to RESUME.
- RESUME:
  - Capture `pop_data` into `save_pc[31:16]`.
  - `pc_load=1`, `pc_load_addr={pop_data, save_pc[15:0]}`, `int_count=3`.
  - Clear `in_isr`, go to IDLE.
- `rti` while `!in_isr` is ignored: no pop, no flush.
- `stall_fetch=1` in every non-IDLE state. `flush_fd`/`flush_de` are 0 except as stated.

## Timing
- Reset values: state IDLE, all outputs 0, `pending=0`, `in_isr=0`, `save_pc=0`, `pc_load_addr=0`.
- Edge detect uses a registered copy of `int_req`. `pending` is set the cycle after the rising edge.
- Entry latency: edge at cycle N gives DRAIN at N+2, PUSH_HI at N+2+DRAIN_CYCLES, and `pc_load` at N+4+DRAIN_CYCLES.
- Return latency: `rti` at cycle M gives `pc_load` at M+3.
- If `rti` and `pending` coincide in IDLE, `rti` wins and `pending` is held.
- An edge during a sequence sets `pending`. A second edge while already pending is lost; there is no counting.
- Reset asserted mid-sequence aborts immediately. There is no partial push recovery.
- Outputs are Moore decodes of the state register, except the `rti`-cycle flushes, which are Mealy.

## Configuration
- `INT_NEST_EN` defined: interrupts are accepted while `in_isr`. A 2-bit nest depth counter increments at VECTOR and decrements at RESUME. `in_isr` = depth≠0. Entry is refused at depth 3: `pending` is held.
- Not defined: `pending` is ignored while `in_isr`. It is serviced in the first IDLE cycle after RESUME.

## Test plan
- `int_req` edge at cycle 10, `pc_next`=32'h0001_0040 → pushes 16'h0001 then 16'h0040; `pc_load` with 32'h0000_0002 at cycle 17 (DRAIN_CYCLES=3); `in_isr`=1.
- After entry, `rti` pulse, `pop_data`=16'h0040 then 16'h0001 → `pc_load_addr`=32'h0001_0040 exactly 3 cycles later; `in_isr`=0.
- `rti` and `pending` in the same IDLE cycle (`in_isr`=1) → pop sequence runs first, then interrupt entry starts in the next IDLE cycle.
- Reset low during PUSH_LO → all outputs 0 immediately, state IDLE, `pending`=0.
- `rti` with `in_isr`=0 → no `pop_req`, no flushes, state stays IDLE.
- Second `int_req` edge while `in_isr` → without `INT_NEST_EN` it is held until after RESUME; with it, a nested push occurs and depth=2.

Source files
------------

// File: rtl/int_sequencer.sv
// Interrupt entry/return sequencer: drains the pipeline, pushes/pops the resume PC and redirects fetch.
// Optional build macro INT_NEST_EN enables nested interrupts with a 2-bit depth counter.
module int_sequencer #(
    parameter int              PC_W         = 32,
    parameter int              DRAIN_CYCLES = 3,
    parameter logic [PC_W-1:0] VECTOR_ADDR  = 32'h0000_0002
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            int_req,
    input  logic            rti,
    input  logic [PC_W-1:0] pc_next,
    input  logic [15:0]     pop_data,
    output logic            stall_fetch,
    output logic            flush_fd,
    output logic            flush_de,
    output logic            push_req,
    output logic [15:0]     push_data,
    output logic            pop_req,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_load_addr,
    output logic [1:0]      int_count,
    output logic            in_isr,
    output logic            busy
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, DRAIN, PUSH_HI, PUSH_LO, VECTOR, POP_LO, POP_HI, RESUME
    } seqState_e;

    seqState_e        state, nextState;
    logic [CNT_W-1:0] drainCnt;
    logic             intReqQ;
    logic             pending;
    logic [PC_W-1:0]  savePc;
    logic             inIsr;
    logic             entryOk;
    logic             intEdge;
    logic             rtiAccept;

    logic             stallQ, flushFdQ, pushReqQ, popReqQ, pcLoadQ, busyQ;
    logic [1:0]       intCountQ;
    logic [1:0]       nextCount;

`ifdef INT_NEST_EN
    logic [1:0] nestDepth;
    assign inIsr   = (nestDepth != 2'd0);
    assign entryOk = (nestDepth != 2'd3);
`else
    logic inIsrQ;
    assign inIsr   = inIsrQ;
    assign entryOk = !inIsrQ;
`endif

    assign intEdge   = int_req && !intReqQ;
    assign rtiAccept = (state == IDLE) && rti && inIsr;

    // An accepted RTI beats a pending interrupt; the interrupt stays pending.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (rtiAccept)
                    nextState = POP_LO;
                else if (pending && entryOk)
                    nextState = DRAIN;
            end
            DRAIN:   if (drainCnt == '0) nextState = PUSH_HI;
            PUSH_HI: nextState = PUSH_LO;
            PUSH_LO: nextState = VECTOR;
            VECTOR:  nextState = IDLE;
            POP_LO:  nextState = POP_HI;
            POP_HI:  nextState = RESUME;
            RESUME:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        nextCount = 2'd0;
        case (nextState)
            DRAIN:                           nextCount = 2'd1;
            PUSH_HI, PUSH_LO, POP_LO, POP_HI: nextCount = 2'd2;
            VECTOR, RESUME:                  nextCount = 2'd3;
            default:                         nextCount = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            drainCnt  <= '0;
            intReqQ   <= 1'b0;
            pending   <= 1'b0;
            savePc    <= '0;
`ifdef INT_NEST_EN
            nestDepth <= 2'd0;
`else
            inIsrQ    <= 1'b0;
`endif
            stallQ    <= 1'b0;
            flushFdQ  <= 1'b0;
            pushReqQ  <= 1'b0;
            popReqQ   <= 1'b0;
            pcLoadQ   <= 1'b0;
            busyQ     <= 1'b0;
            intCountQ <= 2'd0;
        end else begin
            // NOTE: state and every flop here use non-blocking assignment so all of them see pre-edge values.
            state   <= nextState;
            intReqQ <= int_req;

            // A fresh edge wins over the VECTOR clear so it is not lost.
            if (intEdge)
                pending <= 1'b1;
            else if (state == VECTOR)
                pending <= 1'b0;

            if (state == IDLE && nextState == DRAIN)
                drainCnt <= CNT_W'(DRAIN_CYCLES - 1);
            else if (state == DRAIN && drainCnt != '0)
                drainCnt <= drainCnt - CNT_W'(1);

            case (state)
                DRAIN:   if (drainCnt == '0) savePc <= pc_next;
                POP_HI:  savePc[15:0] <= pop_data;
                RESUME:  savePc[PC_W-1:16] <= pop_data;
                default: ;
            endcase

`ifdef INT_NEST_EN
            if (state == VECTOR)
                nestDepth <= nestDepth + 2'd1;
            else if (state == RESUME)
                nestDepth <= nestDepth - 2'd1;
`else
            if (state == VECTOR)
                inIsrQ <= 1'b1;
            else if (state == RESUME)
                inIsrQ <= 1'b0;
`endif

            // Control outputs are registered from the next state so they match the state they decode.
            stallQ    <= (nextState != IDLE);
            busyQ     <= (nextState != IDLE);
            flushFdQ  <= (nextState == DRAIN);
            pushReqQ  <= (nextState == PUSH_HI) || (nextState == PUSH_LO);
            popReqQ   <= (nextState == POP_LO) || (nextState == POP_HI);
            pcLoadQ   <= (nextState == VECTOR) || (nextState == RESUME);
            intCountQ <= nextCount;
        end
    end

    // RESUME forwards the high half straight from the stack read port.
    always_comb begin
        push_data    = '0;
        pc_load_addr = '0;
        case (state)
            PUSH_HI: push_data    = savePc[PC_W-1:16];
            PUSH_LO: push_data    = savePc[15:0];
            VECTOR:  pc_load_addr = VECTOR_ADDR;
            RESUME:  pc_load_addr = {pop_data, savePc[15:0]};
            default: ;
        endcase
    end

    assign stall_fetch = stallQ;
    assign flush_fd    = flushFdQ || rtiAccept;
    assign flush_de    = rtiAccept;
    assign push_req    = pushReqQ;
    assign pop_req     = popReqQ;
    assign pc_load     = pcLoadQ;
    assign int_count   = intCountQ;
    assign in_isr      = inIsr;
    assign busy        = busyQ;

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: cycle trace table plus hand-written corner sequences.
// Expectations follow the default build unless INT_NEST_EN is defined.
module tb_int_sequencer;

    logic        clk;
    logic        reset;
    logic        int_req;
    logic        rti;
    logic [31:0] pc_next;
    logic [15:0] pop_data;
    logic        stall_fetch, flush_fd, flush_de, push_req, pop_req, pc_load, in_isr, busy;
    logic [15:0] push_data;
    logic [31:0] pc_load_addr;
    logic [1:0]  int_count;

    int passed = 0;
    int total  = 0;

    int_sequencer #(.PC_W(32), .DRAIN_CYCLES(3), .VECTOR_ADDR(32'h0000_0002)) dut (
        .clk(clk), .reset(reset), .int_req(int_req), .rti(rti),
        .pc_next(pc_next), .pop_data(pop_data),
        .stall_fetch(stall_fetch), .flush_fd(flush_fd), .flush_de(flush_de),
        .push_req(push_req), .push_data(push_data), .pop_req(pop_req),
        .pc_load(pc_load), .pc_load_addr(pc_load_addr), .int_count(int_count),
        .in_isr(in_isr), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Flag order: {busy, stall_fetch, flush_fd, flush_de, push_req, pop_req, pc_load, in_isr, int_count}
    typedef struct {
        logic        rti;
        logic        intReq;
        logic [31:0] pcNext;
        logic [15:0] popData;
        logic [9:0]  flags;
        logic [15:0] pushData;
        logic [31:0] pcAddr;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] pn,
                                input logic [15:0] pd, input logic [9:0] fl,
                                input logic [15:0] pu, input logic [31:0] pa);
        vec_t v;
        v.rti = r; v.intReq = ir; v.pcNext = pn; v.popData = pd;
        v.flags = fl; v.pushData = pu; v.pcAddr = pa;
        return v;
    endfunction

    function automatic logic [9:0] flagsNow();
        return {busy, stall_fetch, flush_fd, flush_de, push_req, pop_req, pc_load, in_isr, int_count};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic checkOut(input string name, input logic [9:0] fl, input logic [15:0] pu,
                            input logic [31:0] pa);
        check($sformatf("%s.flags", name), 64'(flagsNow()), 64'(fl));
        check($sformatf("%s.push_data", name), 64'(push_data), 64'(pu));
        check($sformatf("%s.pc_load_addr", name), 64'(pc_load_addr), 64'(pa));
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Triggers an entry from IDLE and waits (bounded) for the vector redirect.
    task automatic doEntry(input string name);
        int n;
        nextCycle(); int_req = 1'b0;
        nextCycle(); int_req = 1'b1;
        n = 0;
        @(negedge clk);
        while (!pc_load && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, ".vector_load"}, {31'h0, pc_load, pc_load_addr}, {31'h0, 1'b1, 32'h0000_0002});
        @(negedge clk);
        check({name, ".in_isr"}, 64'(in_isr), 64'd1);
    endtask

    localparam logic [31:0] P = 32'hDEAD_BEEF;
    localparam logic [15:0] D = 16'hFFFF;

    initial begin
        bit sawBusy;

        reset = 1'b0; int_req = 1'b0; rti = 1'b0; pc_next = '0; pop_data = '0;

        vecs[0]  = mk(0, 0, P,            D,        10'b0000000000, 16'h0000, 32'h0);
        vecs[1]  = mk(0, 1, P,            D,        10'b0000000000, 16'h0000, 32'h0);
        vecs[2]  = mk(0, 1, P,            D,        10'b0000000000, 16'h0000, 32'h0);
        vecs[3]  = mk(0, 1, P,            D,        10'b1110000001, 16'h0000, 32'h0);
        vecs[4]  = mk(0, 1, P,            D,        10'b1110000001, 16'h0000, 32'h0);
        vecs[5]  = mk(0, 1, 32'h0001_0040, D,       10'b1110000001, 16'h0000, 32'h0);
        vecs[6]  = mk(0, 1, P,            D,        10'b1100100010, 16'h0001, 32'h0);
        vecs[7]  = mk(0, 1, P,            D,        10'b1100100010, 16'h0040, 32'h0);
        vecs[8]  = mk(0, 1, P,            D,        10'b1100001011, 16'h0000, 32'h0000_0002);
        vecs[9]  = mk(0, 1, P,            D,        10'b0000000100, 16'h0000, 32'h0);
        vecs[10] = mk(0, 0, P,            D,        10'b0000000100, 16'h0000, 32'h0);
        vecs[11] = mk(1, 0, P,            D,        10'b0011000100, 16'h0000, 32'h0);
        vecs[12] = mk(0, 0, P,            D,        10'b1100010110, 16'h0000, 32'h0);
        vecs[13] = mk(0, 0, P,            16'h0040, 10'b1100010110, 16'h0000, 32'h0);
        vecs[14] = mk(0, 0, P,            16'h0001, 10'b1100001111, 16'h0000, 32'h0001_0040);
        vecs[15] = mk(0, 0, P,            D,        10'b0000000000, 16'h0000, 32'h0);
        vecs[16] = mk(1, 0, P,            D,        10'b0000000000, 16'h0000, 32'h0);
        vecs[17] = mk(0, 0, P,            D,        10'b0000000000, 16'h0000, 32'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOut("reset", 10'b0, 16'h0, 32'h0);
        nextCycle();
        reset = 1'b1;

        // Entry, return, and an ignored RTI, one table row per clock.
        for (int i = 0; i < 18; i++) begin
            nextCycle();
            rti = vecs[i].rti; int_req = vecs[i].intReq;
            pc_next = vecs[i].pcNext; pop_data = vecs[i].popData;
            @(negedge clk);
            checkOut($sformatf("row%0d", i), vecs[i].flags, vecs[i].pushData, vecs[i].pcAddr);
        end

        // Reset asserted in PUSH_LO aborts and leaves nothing pending.
        pc_next = 32'h1234_5678; pop_data = '0;
        nextCycle(); int_req = 1'b1;
        repeat (6) nextCycle();
        checkOut("C.push_lo", 10'b1100100010, 16'h5678, 32'h0);
        reset = 1'b0; int_req = 1'b0;
        #1;
        checkOut("C.abort", 10'b0, 16'h0, 32'h0);
        nextCycle();
        reset = 1'b1;
        sawBusy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            @(negedge clk);
            if (busy || in_isr) sawBusy = 1'b1;
        end
        check("C.no_reentry", 64'(sawBusy), 64'd0);

        // RTI and pending coincide in IDLE: the pop runs first, entry follows.
        doEntry("A0");
        nextCycle(); int_req = 1'b0;
        nextCycle(); int_req = 1'b1;
        nextCycle(); rti = 1'b1;
        @(negedge clk); checkOut("A.rti", 10'b0011000100, 16'h0, 32'h0);
        nextCycle(); rti = 1'b0;
        @(negedge clk); checkOut("A.pop_lo", 10'b1100010110, 16'h0, 32'h0);
        nextCycle(); pop_data = 16'hBEEF;
        @(negedge clk); checkOut("A.pop_hi", 10'b1100010110, 16'h0, 32'h0);
        nextCycle(); pop_data = 16'h00AB;
        @(negedge clk); checkOut("A.resume", 10'b1100001111, 16'h0, 32'h00AB_BEEF);
        nextCycle(); pop_data = 16'h0000;
        @(negedge clk); checkOut("A.idle", 10'b0000000000, 16'h0, 32'h0);
        nextCycle();
        @(negedge clk); checkOut("A.drain", 10'b1110000001, 16'h0, 32'h0);
        begin
            int n;
            n = 0;
            while (!pc_load && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("A.vector_load", {31'h0, pc_load, pc_load_addr}, {31'h0, 1'b1, 32'h0000_0002});
        end
        @(negedge clk);
        check("A.in_isr", 64'(in_isr), 64'd1);

        // Second edge while in the handler.
        nextCycle(); int_req = 1'b0;
        nextCycle(); int_req = 1'b1;
`ifdef INT_NEST_EN
        nextCycle();
        nextCycle();
        @(negedge clk); checkOut("B.nest_drain", 10'b1110000101, 16'h0, 32'h0);
        begin
            int n;
            n = 0;
            while (!pc_load && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("B.nest_vector", {31'h0, pc_load, pc_load_addr}, {31'h0, 1'b1, 32'h0000_0002});
        end
        @(negedge clk);
        check("B.nest_depth", 64'(dut.nestDepth), 64'd2);
`else
        sawBusy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            @(negedge clk);
            if (busy) sawBusy = 1'b1;
        end
        check("B.held", 64'(sawBusy), 64'd0);
        nextCycle(); rti = 1'b1;
        nextCycle(); rti = 1'b0;
        nextCycle(); pop_data = 16'h1111;
        nextCycle(); pop_data = 16'h2222;
        @(negedge clk); checkOut("B.resume", 10'b1100001111, 16'h0, 32'h2222_1111);
        nextCycle(); pop_data = 16'h0000;
        @(negedge clk); checkOut("B.idle", 10'b0000000000, 16'h0, 32'h0);
        nextCycle();
        @(negedge clk); checkOut("B.drain", 10'b1110000001, 16'h0, 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
